palette_arbiter: RTL and testbench
==================================

Name: palette_arbiter

Overview:
- Shares the write port of the mixer's 256x24 palette RAM between NREQ requesters, e.g. damage flash, flame colour cycling and life-bar tint.
- Writes are issued only during vertical blanking, so a palette entry never changes mid-frame.
- Requesters are served round-robin, limited by a per-blank write budget.
- Index 137 is the transparent index of the sprite layers; writes to it are refused with a NAK.

Parameters:
- NREQ, 4, number of requesters (2..8).
- MAX_WR, 16, maximum palette writes committed per vertical-blank period (1..255).
- TRANSP_IDX, 8'd137, reserved transparent palette index; never written.

Ports:
- clk  in  1  pixel clock.
- reset_n  in  1  asynchronous reset, active low.
- vblank  in  1  high during vertical blanking (synchronous to clk).
- req  in  NREQ  per-requester write request; held until ack.
- req_addr  in  NREQ*8  packed palette index, requester i at [8i+7:8i].
- req_data  in  NREQ*24  packed RGB 8:8:8, requester i at [24i+23:24i].
- ack  out  NREQ  one-cycle acknowledge to the granted requester.
- nak  out  1  valid with ack; 1 = write refused (address == TRANSP_IDX).
- pal_we  out  1  palette RAM write enable, one-cycle pulse.
- pal_waddr  out  8  palette RAM write address.
- pal_wdata  out  24  palette RAM write data.
- budget_left  out  8  writes remaining in the current blank.

Behaviour:
- Reset (async, reset_n=0) values:
  - ack=0, nak=0, pal_we=0, pal_waddr=0, pal_wdata=0.
  - budget_left=MAX_WR, state=IDLE, rr_ptr=0, vblank_r=0.
- All outputs are registered.
- FSM has two states, IDLE and HOLD.
- IDLE, grant condition: vblank=1 AND any req AND budget_left!=0.
  - Winner = first requester with req=1, scanning rr_ptr, rr_ptr+1, … modulo NREQ.
  - Normal write, on the clock edge: pal_we<=1, pal_waddr/pal_wdata<=winner's addr/data, ack[winner]<=1, nak<=0, budget_left decrements by 1, state<=HOLD.
  - Winner addr == TRANSP_IDX: ack[winner]<=1, nak<=1, pal_we stays 0, budget unchanged.
  - In both cases rr_ptr<=winner+1 mod NREQ.
- IDLE, no grant condition: outputs stay 0 and state stays IDLE.
- HOLD: pal_we, ack and nak return to 0; state<=IDLE. No grant is made in HOLD. This gives the requester one cycle to drop req after seeing ack.
- Throughput: one write per 2 cycles. Latency from req sampled in IDLE to ack/pal_we is 1 cycle.
- Requester contract:
  - Hold req, addr and data stable until ack.
  - Drop req in the cycle after ack, unless another write is queued with new addr/data.
  - req asserted again in the cycle after ack counts as a new request.
- Budget:
  - vblank_r is a registered copy of vblank.
  - On a rising edge (vblank=1, vblank_r=0), budget_left<=MAX_WR.
  - If a reload and a grant fall in the same cycle, the reload wins and then the decrement applies: MAX_WR-1 for a real write, MAX_WR for a NAK.
- budget_left==0: requests stay pending, without ack, until the next blank.
- vblank falls while in HOLD: the issued write stands (it is already in the RAM), and HOLD completes normally.
- vblank=0 in IDLE: no grant. Pending reqs wait.
- Simultaneous reqs are resolved by rr_ptr only, with no fixed priority.
- req dropped without ack (abort) is legal only while vblank=0. Otherwise the request may already be granted.
- Reset mid-operation aborts any pending write, and its ack is lost. Requesters must also reset.

Decomposition:
- Package palette_pkg holds:
  - TRANSP_IDX = 8'd137;
  - typedef rgb_t (logic [23:0]);
  - typedef pal_idx_t (logic [7:0]).
- The mixer uses the same package.
- One sub-module, rr_pick: combinational round-robin picker. Inputs req[NREQ] and rr_ptr; outputs grant_valid and grant_idx.

Test Plan:
- NREQ=4, MAX_WR=16, vblank=1, req[2]=1, addr 8'h10, data 24'hFF0000 → 1 cycle later pal_we=1, waddr=8'h10, wdata=24'hFF0000, ack=4'b0100, nak=0, budget_left=15; next cycle all low.
- req=4'b1111 held (re-asserted after each ack), rr_ptr=0, vblank=1 → ack order 0,1,2,3,0; pal_we every 2nd cycle.
- req[1]=1, addr 8'd137 → ack[1]=1, nak=1, pal_we never asserted, budget unchanged.
- MAX_WR=2, req[0] with 3 queued writes → 2 writes committed, 3rd stalls with budget_left=0; after vblank falls and rises again it is written, budget_left=1.
- req[3]=1 while vblank=0 for 100 cycles → no ack/pal_we; vblank rises → pal_we within 1 cycle of the rising edge.
- reset_n pulled low in the cycle after grant (HOLD) → all outputs 0 immediately (async), budget_left=MAX_WR, rr_ptr=0.

Source files
------------

// File: rtl/palette_pkg.sv
// Shared palette definitions, used by the palette arbiter and by the mixer.
package palette_pkg;

  // Transparent index of the sprite layers; this entry is never overwritten.
  localparam logic [7:0] TRANSP_IDX = 8'd137;

  typedef logic [23:0] rgb_t;
  typedef logic [7:0]  pal_idx_t;

  // True when a palette index is the reserved one and must not be written.
  function automatic logic is_reserved(input pal_idx_t addr, input pal_idx_t reserved);
    return addr == reserved;
  endfunction

endpackage

// File: rtl/palette_arbiter_rr_pick.sv
// Combinational round-robin picker: the first active request found when
// scanning from rr_ptr upward, wrapping modulo NREQ.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   rr_ptr,
  output logic            grant_valid,
  output logic [PW-1:0]   grant_idx
);

  int pos;

  // Scan from the farthest offset back to rr_ptr so the nearest hit is the last one written.
  always_comb begin
    grant_valid = |req;
    grant_idx   = '0;
    pos         = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      pos = (int'(rr_ptr) + k) % NREQ;
      if (req[pos]) begin
        grant_idx = pos[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/palette_arbiter.sv
// Palette RAM write-port arbiter: serves NREQ requesters round-robin, only
// during vertical blanking, within a per-blank write budget, and refuses
// writes to the transparent index with a NAK.
module palette_arbiter #(
  parameter int         NREQ       = 4,
  parameter int         MAX_WR     = 16,
  parameter logic [7:0] TRANSP_IDX = palette_pkg::TRANSP_IDX
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               vblank,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*8-1:0]  req_addr,
  input  logic [NREQ*24-1:0] req_data,
  output logic [NREQ-1:0]    ack,
  output logic               nak,
  output logic               pal_we,
  output logic [7:0]         pal_waddr,
  output logic [23:0]        pal_wdata,
  output logic [7:0]         budget_left
);

  import palette_pkg::*;

  localparam int         PW          = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [0:0] IDLE        = 1'b0;
  localparam logic [0:0] HOLD        = 1'b1;
  localparam logic [7:0] BUDGET_FULL = 8'(MAX_WR);
  localparam logic [PW-1:0] LAST_REQ = PW'(NREQ - 1);

  logic [0:0]      state;
  logic [0:0]      state_next;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   rr_ptr_next;
  logic            vblank_r;
  logic            grant_valid;
  logic [PW-1:0]   grant_idx;
  pal_idx_t        win_addr;
  rgb_t            win_data;
  logic            reload;
  logic            grant;
  logic            refused;
  logic [7:0]      budget_eff;
  logic [7:0]      budget_next;
  logic [NREQ-1:0] ack_next;
  logic            nak_next;
  logic            we_next;
  pal_idx_t        waddr_next;
  rgb_t            wdata_next;

  rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .req         (req),
    .rr_ptr      (rr_ptr),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  assign win_addr = req_addr[8*grant_idx +: 8];
  assign win_data = req_data[24*grant_idx +: 24];

  // A blank's rising edge refills the budget before any grant in that same cycle spends it.
  assign reload     = vblank & ~vblank_r;
  assign budget_eff = reload ? BUDGET_FULL : budget_left;
  assign grant      = (state == IDLE) & vblank & grant_valid & (budget_eff != 8'd0);
  assign refused    = is_reserved(win_addr, TRANSP_IDX);

  // Next-state decode: a grant moves to HOLD, HOLD always returns to IDLE with pulses cleared.
  always_comb begin
    state_next  = IDLE;
    rr_ptr_next = rr_ptr;
    budget_next = budget_eff;
    ack_next    = '0;
    nak_next    = 1'b0;
    we_next     = 1'b0;
    waddr_next  = pal_waddr;
    wdata_next  = pal_wdata;
    if (grant) begin
      state_next          = HOLD;
      ack_next[grant_idx] = 1'b1;
      rr_ptr_next         = (grant_idx == LAST_REQ) ? '0 : grant_idx + 1'b1;
      if (refused) begin
        nak_next = 1'b1;
      end else begin
        we_next     = 1'b1;
        waddr_next  = win_addr;
        wdata_next  = win_data;
        budget_next = budget_eff - 8'd1;
      end
    end
  end

  // Registered state and outputs; reset drops every pending write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      vblank_r    <= 1'b0;
      budget_left <= BUDGET_FULL;
      ack         <= '0;
      nak         <= 1'b0;
      pal_we      <= 1'b0;
      pal_waddr   <= '0;
      pal_wdata   <= '0;
    end else begin
      state       <= state_next;
      rr_ptr      <= rr_ptr_next;
      vblank_r    <= vblank;
      budget_left <= budget_next;
      ack         <= ack_next;
      nak         <= nak_next;
      pal_we      <= we_next;
      pal_waddr   <= waddr_next;
      pal_wdata   <= wdata_next;
    end
  end

endmodule

// File: tb/tb_palette_arbiter.sv
// Self-checking bench for palette_arbiter: a table of single transactions
// plus hand-written sequences for round-robin, blanking, budget and reset.
module tb_palette_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        vblank;
  logic [3:0]  req;
  logic [31:0] req_addr;
  logic [95:0] req_data;
  logic [3:0]  ack;
  logic        nak;
  logic        pal_we;
  logic [7:0]  pal_waddr;
  logic [23:0] pal_wdata;
  logic [7:0]  budget_left;

  logic [3:0]  req2;
  logic [31:0] req_addr2;
  logic [95:0] req_data2;
  logic [3:0]  ack2;
  logic        nak2;
  logic        pal_we2;
  logic [7:0]  pal_waddr2;
  logic [23:0] pal_wdata2;
  logic [7:0]  budget_left2;

  int tests = 0;
  int fails = 0;

  palette_arbiter #(.NREQ(4), .MAX_WR(16)) dut (
    .clk (clk), .reset_n (reset_n), .vblank (vblank),
    .req (req), .req_addr (req_addr), .req_data (req_data),
    .ack (ack), .nak (nak), .pal_we (pal_we),
    .pal_waddr (pal_waddr), .pal_wdata (pal_wdata), .budget_left (budget_left)
  );

  palette_arbiter #(.NREQ(4), .MAX_WR(2)) dut2 (
    .clk (clk), .reset_n (reset_n), .vblank (vblank),
    .req (req2), .req_addr (req_addr2), .req_data (req_data2),
    .ack (ack2), .nak (nak2), .pal_we (pal_we2),
    .pal_waddr (pal_waddr2), .pal_wdata (pal_wdata2), .budget_left (budget_left2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        vb;
    logic [3:0]  rq;
    logic [31:0] addr;
    logic [95:0] data;
    logic [3:0]  ack;
    logic        nak;
    logic        we;
    logic [7:0]  waddr;
    logic [23:0] wdata;
    logic [7:0]  budget;
  } vec_t;

  vec_t vecs[8];

  localparam logic [31:0] ADDRS    = {8'h33, 8'h10, 8'h21, 8'h20};
  localparam logic [31:0] ADDRS_NK = {8'h33, 8'h10, 8'd137, 8'h20};
  localparam logic [95:0] DATAS    = {24'h0000FF, 24'hFF0000, 24'h00FF00, 24'h123456};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [95:0] act, input logic [95:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    vblank   = v.vb;
    req      = v.rq;
    req_addr = v.addr;
    req_data = v.data;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    vblank  = 1'b0;
    req     = '0;
    req2    = '0;
    @(negedge clk);
    reset_n = 1'b1;
    tick();
  endtask

  int hits;

  initial begin
    vecs[0] = '{1'b1, 4'b0100, ADDRS,    DATAS, 4'b0100, 1'b0, 1'b1, 8'h10, 24'hFF0000, 8'd15};
    vecs[1] = '{1'b1, 4'b0011, ADDRS,    DATAS, 4'b0001, 1'b0, 1'b1, 8'h20, 24'h123456, 8'd14};
    vecs[2] = '{1'b1, 4'b0011, ADDRS,    DATAS, 4'b0010, 1'b0, 1'b1, 8'h21, 24'h00FF00, 8'd13};
    vecs[3] = '{1'b1, 4'b0010, ADDRS_NK, DATAS, 4'b0010, 1'b1, 1'b0, 8'h00, 24'h000000, 8'd13};
    vecs[4] = '{1'b1, 4'b1001, ADDRS,    DATAS, 4'b1000, 1'b0, 1'b1, 8'h33, 24'h0000FF, 8'd12};
    vecs[5] = '{1'b1, 4'b1001, ADDRS,    DATAS, 4'b0001, 1'b0, 1'b1, 8'h20, 24'h123456, 8'd11};
    vecs[6] = '{1'b1, 4'b0000, ADDRS,    DATAS, 4'b0000, 1'b0, 1'b0, 8'h00, 24'h000000, 8'd11};
    vecs[7] = '{1'b0, 4'b1000, ADDRS,    DATAS, 4'b0000, 1'b0, 1'b0, 8'h00, 24'h000000, 8'd11};

    reset_n   = 1'b0;
    vblank    = 1'b0;
    req       = '0;
    req_addr  = ADDRS;
    req_data  = DATAS;
    req2      = '0;
    req_addr2 = '0;
    req_data2 = '0;
    #12;
    checkOutput("reset_ack",    96'(ack),         96'(4'b0000));
    checkOutput("reset_nak",    96'(nak),         96'(1'b0));
    checkOutput("reset_we",     96'(pal_we),      96'(1'b0));
    checkOutput("reset_waddr",  96'(pal_waddr),   96'(8'h00));
    checkOutput("reset_wdata",  96'(pal_wdata),   96'(24'h0));
    checkOutput("reset_budget", 96'(budget_left), 96'(8'd16));
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // Open the blank with no requests, then run the table.
    vblank = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i]);
      tick();
      checkOutput($sformatf("v%0d_ack", i),    96'(ack),         96'(vecs[i].ack));
      checkOutput($sformatf("v%0d_nak", i),    96'(nak),         96'(vecs[i].nak));
      checkOutput($sformatf("v%0d_we", i),     96'(pal_we),      96'(vecs[i].we));
      checkOutput($sformatf("v%0d_budget", i), 96'(budget_left), 96'(vecs[i].budget));
      if (vecs[i].we) begin
        checkOutput($sformatf("v%0d_waddr", i), 96'(pal_waddr), 96'(vecs[i].waddr));
        checkOutput($sformatf("v%0d_wdata", i), 96'(pal_wdata), 96'(vecs[i].wdata));
      end
      req = '0;
      tick();
      checkOutput($sformatf("v%0d_hold_pulses", i), 96'({ack, nak, pal_we}), 96'(6'b0));
      checkOutput($sformatf("v%0d_hold_budget", i), 96'(budget_left), 96'(vecs[i].budget));
    end

    // Requester 3 waits outside the blank, then is served on the rising edge.
    vblank = 1'b0;
    req    = 4'b1000;
    hits   = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (ack != 4'b0000 || pal_we) hits++;
    end
    checkOutput("noblank_grants", 96'(hits), 96'(0));
    vblank = 1'b1;
    tick();
    checkOutput("rise_ack",    96'(ack),         96'(4'b1000));
    checkOutput("rise_we",     96'(pal_we),      96'(1'b1));
    checkOutput("rise_waddr",  96'(pal_waddr),   96'(8'h33));
    checkOutput("rise_budget", 96'(budget_left), 96'(8'd15));
    req = '0;
    tick();

    // All four requesters keep asking: grants rotate 0,1,2,3,0 on alternate cycles.
    do_reset();
    vblank = 1'b1;
    req    = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i % 2 == 0) begin
        checkOutput($sformatf("rr%0d_ack", i), 96'(ack),    96'(4'b0001 << ((i / 2) % 4)));
        checkOutput($sformatf("rr%0d_we", i),  96'(pal_we), 96'(1'b1));
      end else begin
        checkOutput($sformatf("rr%0d_idle", i), 96'({ack, pal_we}), 96'(5'b0));
      end
    end
    checkOutput("rr_budget", 96'(budget_left), 96'(8'd11));

    // Reset arriving in HOLD clears everything at once and rewinds the pointer.
    req = 4'b0010;
    tick();
    checkOutput("pre_rst_ack", 96'(ack), 96'(4'b0010));
    #1;
    reset_n = 1'b0;
    #1;
    checkOutput("rst_hold_pulses", 96'({ack, nak, pal_we}), 96'(6'b0));
    checkOutput("rst_hold_waddr",  96'(pal_waddr),   96'(8'h00));
    checkOutput("rst_hold_wdata",  96'(pal_wdata),   96'(24'h0));
    checkOutput("rst_hold_budget", 96'(budget_left), 96'(8'd16));
    @(negedge clk);
    reset_n = 1'b1;
    req     = 4'b1111;
    tick();
    checkOutput("rst_ptr_ack", 96'(ack), 96'(4'b0001));
    req = '0;
    tick();

    // Budget of two: the third queued write waits for the next blank.
    do_reset();
    vblank    = 1'b1;
    req2      = 4'b0001;
    req_addr2 = {24'h0, 8'h40};
    req_data2 = {72'h0, 24'hAAAAAA};
    tick();
    checkOutput("b_w1_ack",    96'(ack2),         96'(4'b0001));
    checkOutput("b_w1_budget", 96'(budget_left2), 96'(8'd1));
    req_addr2 = {24'h0, 8'h41};
    tick();
    tick();
    checkOutput("b_w2_waddr",  96'(pal_waddr2),   96'(8'h41));
    checkOutput("b_w2_budget", 96'(budget_left2), 96'(8'd0));
    req_addr2 = {24'h0, 8'h42};
    hits      = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (ack2 != 4'b0000 || pal_we2) hits++;
    end
    vblank = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (ack2 != 4'b0000 || pal_we2) hits++;
    end
    checkOutput("b_stall_grants", 96'(hits),         96'(0));
    checkOutput("b_stall_budget", 96'(budget_left2), 96'(8'd0));
    vblank = 1'b1;
    tick();
    checkOutput("b_w3_ack",    96'(ack2),         96'(4'b0001));
    checkOutput("b_w3_we",     96'(pal_we2),      96'(1'b1));
    checkOutput("b_w3_waddr",  96'(pal_waddr2),   96'(8'h42));
    checkOutput("b_w3_budget", 96'(budget_left2), 96'(8'd1));
    req2 = '0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
